// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one combinational add/subtract core among NREQ requesters.
// Each granted op takes three cycles (IDLE -> EXEC -> DONE) and returns a one-cycle ack.
module addsub_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4,
   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ-1:0]       req_sub,
   output logic [NREQ-1:0]       ack,
   output logic [NREQ-1:0]       grant,
   output logic                  busy,
   output logic [WIDTH-1:0]      res_sum,
   output logic                  res_cf,
   output logic                  res_ovf,
   output logic                  res_sf,
   output logic                  res_zf,
   output logic [IDW-1:0]        res_id
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             state_r, state_nx_s;
   logic [IDW-1:0]     last_r, id_r, pick_s;
   logic               found_s;
   int                 idx_s;
   logic [WIDTH-1:0]   a_r, b_r, b_eff_s, sum_s;
   logic               sub_r, cf_s, ovf_s;
   logic [WIDTH:0]     ext_s;
   logic [NREQ-1:0]    grant_r, ack_r;
   logic               busy_r;
   logic [WIDTH-1:0]   res_sum_r;
   logic               res_cf_r, res_ovf_r, res_sf_r, res_zf_r;
   logic [IDW-1:0]     res_id_r;

   // Round-robin pick: first requester after the last one served, wrapping around.
   always_comb begin
      pick_s  = {IDW{1'b0}};
      found_s = 1'b0;
      idx_s   = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx_s = (int'(last_r) + k) % NREQ;
         if (!found_s && req[idx_s]) begin
            pick_s  = IDW'(idx_s);
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Shared add/subtract core driven by the latched operands.
   always_comb begin
      b_eff_s = sub_r ? ~b_r : b_r;
      ext_s   = {1'b0, a_r} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, sub_r};
      sum_s   = ext_s[WIDTH-1:0];
      cf_s    = sub_r ? ~ext_s[WIDTH] : ext_s[WIDTH];
      if (sub_r) begin
         ovf_s = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (sum_s[WIDTH-1] != a_r[WIDTH-1]);
      end else begin
         ovf_s = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_s[WIDTH-1] != a_r[WIDTH-1]);
      end
   end

   // Next-state logic; arbitration only happens in IDLE.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (found_s) begin
               state_nx_s = ST_EXEC;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_EXEC: state_nx_s = ST_DONE;
         ST_DONE: state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Grant/ack/busy and operand latch; operands are sampled only when leaving IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_r  <= IDW'(NREQ - 1);
         id_r    <= {IDW{1'b0}};
         a_r     <= {WIDTH{1'b0}};
         b_r     <= {WIDTH{1'b0}};
         sub_r   <= 1'b0;
         grant_r <= {NREQ{1'b0}};
         ack_r   <= {NREQ{1'b0}};
         busy_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (found_s) begin
                  a_r     <= req_a[int'(pick_s)*WIDTH +: WIDTH];
                  b_r     <= req_b[int'(pick_s)*WIDTH +: WIDTH];
                  sub_r   <= req_sub[pick_s];
                  grant_r <= {{(NREQ-1){1'b0}}, 1'b1} << pick_s;
                  last_r  <= pick_s;
                  id_r    <= pick_s;
                  busy_r  <= 1'b1;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            ST_EXEC: begin
               ack_r <= grant_r;
            end
            ST_DONE: begin
               ack_r   <= {NREQ{1'b0}};
               grant_r <= {NREQ{1'b0}};
               busy_r  <= 1'b0;
            end
            default: begin
               ack_r   <= {NREQ{1'b0}};
               grant_r <= {NREQ{1'b0}};
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Result capture at the end of EXEC; held until the next op completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_sum_r <= {WIDTH{1'b0}};
         res_cf_r  <= 1'b0;
         res_ovf_r <= 1'b0;
         res_sf_r  <= 1'b0;
         res_zf_r  <= 1'b0;
         res_id_r  <= {IDW{1'b0}};
      end else if (state_r == ST_EXEC) begin
         res_sum_r <= sum_s;
         res_cf_r  <= cf_s;
         res_ovf_r <= ovf_s;
         res_sf_r  <= sum_s[WIDTH-1];
         res_zf_r  <= (sum_s == {WIDTH{1'b0}});
         res_id_r  <= id_r;
      end
   end

   assign ack     = ack_r;
   assign grant   = grant_r;
   assign busy    = busy_r;
   assign res_sum = res_sum_r;
   assign res_cf  = res_cf_r;
   assign res_ovf = res_ovf_r;
   assign res_sf  = res_sf_r;
   assign res_zf  = res_zf_r;
   assign res_id  = res_id_r;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed vector table, rotation/reset sequences,
// and a randomized multi-requester run against an arithmetic round-robin reference model.
module tb_addsub_arbiter;
   localparam int W = 8;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req, req_sub;
   logic [N*W-1:0] req_a, req_b;
   logic [N-1:0]   ack, grant;
   logic           busy, res_cf, res_ovf, res_sf, res_zf;
   logic [W-1:0]   res_sum;
   logic [1:0]     res_id;

   int checks = 0;
   int errors = 0;

   addsub_arbiter #(.WIDTH(W), .NREQ(N)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
      .ack(ack), .grant(grant), .busy(busy), .res_sum(res_sum), .res_cf(res_cf),
      .res_ovf(res_ovf), .res_sf(res_sf), .res_zf(res_zf), .res_id(res_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         id;
      logic [7:0] a, b;
      logic       sub;
      logic [7:0] sum;
      logic       cf, ovf, sf, zf;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic; result packed as {zf, sf, ovf, cf, sum}.
   function automatic logic [11:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic s);
      int ua, ub, u, sa, sb, sr;
      logic [7:0] sum;
      logic cf, ovf;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (s) begin
         u = ua - ub; sr = sa - sb; cf = (ua < ub);
      end else begin
         u = ua + ub; sr = sa + sb; cf = (u > 255);
      end
      sum = u[7:0];
      ovf = (sr > 127) || (sr < -128);
      return {(sum == 8'h00), sum[7], ovf, cf, sum};
   endfunction

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [7:0] rnd8();
      case ($urandom_range(0, 5))
         0: return 8'h00;
         1: return 8'h7F;
         2: return 8'h80;
         3: return 8'hFF;
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic s);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
      req_sub[i]      = s;
   endtask

   task automatic chk_res(input string tag, input logic [11:0] e, input int id);
      chk({tag, "_sum"}, {24'h0, res_sum}, {24'h0, e[7:0]});
      chk({tag, "_cf"},  {31'h0, res_cf},  {31'h0, e[8]});
      chk({tag, "_ovf"}, {31'h0, res_ovf}, {31'h0, e[9]});
      chk({tag, "_sf"},  {31'h0, res_sf},  {31'h0, e[10]});
      chk({tag, "_zf"},  {31'h0, res_zf},  {31'h0, e[11]});
      chk({tag, "_id"},  {30'h0, res_id},  32'(id));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_one(input int id, input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [11:0] e, input string tag);
      int n;
      @(negedge clk);
      set_op(id, a, b, s);
      req = oh(id);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (grant == '0 && n < 8);
      chk({tag, "_grant"}, 32'(grant), 32'(oh(id)));
      chk({tag, "_lat"}, 32'(n), 32'd1);
      chk({tag, "_busy"}, {31'h0, busy}, 32'd1);
      chk({tag, "_ack_early"}, 32'(ack), 32'd0);
      @(negedge clk);
      chk({tag, "_ack"}, 32'(ack), 32'(oh(id)));
      chk_res(tag, e, id);
      req = '0;
      @(negedge clk);
      chk({tag, "_ack_off"}, 32'(ack), 32'd0);
      chk({tag, "_grant_off"}, 32'(grant), 32'd0);
      chk({tag, "_busy_off"}, {31'h0, busy}, 32'd0);
      chk({tag, "_hold"}, {24'h0, res_sum}, {24'h0, e[7:0]});
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         tbl[8];
      logic [7:0]   ra[N], rb[N];
      logic         rs[N];
      int           wt[N];
      int           n, m_left, m_last, m_id, m_resid;
      logic [11:0]  m_res, m_cur, e;
      logic [N-1:0] exp_ack, exp_grant;

      tbl[0] = '{0, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1, 8'h03, 8'h05, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{2, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[3] = '{3, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{2, 8'h2A, 8'h2A, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{2, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[6] = '{3, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[7] = '{0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};

      req = '0; req_a = '0; req_b = '0; req_sub = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", {31'h0, busy}, 32'd0);
      chk_res("rst", 12'h000, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         e = {tbl[i].zf, tbl[i].sf, tbl[i].ovf, tbl[i].cf, tbl[i].sum};
         run_one(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].sub, e, $sformatf("vec%0d", i));
      end

      // All requesters held: service order 0,1,2,3,0, one ack every 3 cycles.
      do_reset();
      @(negedge clk);
      for (int i = 0; i < N; i++) set_op(i, 8'(i*37 + 5), 8'(i*91 + 200), i[0]);
      req = 4'hF;
      for (int k = 0; k < 5; k++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (ack == '0 && n < 10);
         chk($sformatf("rot%0d_ack", k), 32'(ack), 32'(oh(k % N)));
         chk($sformatf("rot%0d_gap", k), 32'(n), (k == 0) ? 32'd2 : 32'd3);
         chk_res($sformatf("rot%0d", k),
                 ref_op(8'((k%N)*37 + 5), 8'((k%N)*91 + 200), 1'((k%N) & 1)), k % N);
      end
      req = '0;
      repeat (2) @(negedge clk);

      // Reset during EXEC abandons the op; afterwards requester 3 alone is served.
      set_op(1, 8'h11, 8'h22, 1'b0);
      req = 4'b0010;
      @(negedge clk);
      chk("mid_grant", 32'(grant), 32'(4'b0010));
      #2 rst_n = 1'b0;
      #1;
      chk("mid_ack", 32'(ack), 32'd0);
      chk("mid_grant0", 32'(grant), 32'd0);
      chk("mid_busy", {31'h0, busy}, 32'd0);
      chk_res("mid", 12'h000, 0);
      req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_noack", 32'(ack), 32'd0);
      set_op(3, 8'h40, 8'h41, 1'b0);
      req = 4'b1000;
      @(negedge clk);
      chk("post_grant", 32'(grant), 32'(4'b1000));
      @(negedge clk);
      chk("post_ack", 32'(ack), 32'(4'b1000));
      chk_res("post", ref_op(8'h40, 8'h41, 1'b0), 3);
      req = '0;
      @(negedge clk);

      // Randomized traffic against a round-robin service model.
      do_reset();
      m_left = 0; m_last = N - 1; m_id = 0; m_resid = 0; m_res = '0; m_cur = '0;
      for (int i = 0; i < N; i++) begin
         ra[i] = '0; rb[i] = '0; rs[i] = 1'b0; wt[i] = 0;
      end
      @(negedge clk);
      for (int cyc = 0; cyc < 600; cyc++) begin
         exp_ack   = (m_left == 1) ? oh(m_id) : 4'b0000;
         exp_grant = (m_left > 0) ? oh(m_id) : 4'b0000;
         chk("rnd_ack", 32'(ack), 32'(exp_ack));
         chk("rnd_grant", 32'(grant), 32'(exp_grant));
         chk("rnd_busy", {31'h0, busy}, (m_left > 0) ? 32'd1 : 32'd0);
         chk("rnd_res", {20'h0, res_zf, res_sf, res_ovf, res_cf, res_sum}, {20'h0, m_res});
         chk("rnd_id", {30'h0, res_id}, 32'(m_resid));

         for (int i = 0; i < N; i++) begin
            if (req[i]) wt[i]++;
            if (ack[i]) begin
               chk("rnd_wait", (wt[i] <= 3*N + 3) ? 32'd1 : 32'd0, 32'd1);
               wt[i] = 0;
               if ($urandom_range(0, 1) == 0) begin
                  req[i] = 1'b0;
               end else begin
                  ra[i] = rnd8(); rb[i] = rnd8(); rs[i] = 1'($urandom);
                  set_op(i, ra[i], rb[i], rs[i]);
               end
            end else if (!req[i] && $urandom_range(0, 2) == 0) begin
               ra[i] = rnd8(); rb[i] = rnd8(); rs[i] = 1'($urandom);
               set_op(i, ra[i], rb[i], rs[i]);
               req[i] = 1'b1;
               wt[i]  = 0;
            end
         end

         if (m_left > 0) begin
            if (m_left == 2) begin
               m_res   = m_cur;
               m_resid = m_id;
            end
            m_left--;
         end else if (req != '0) begin
            for (int k = 1; k <= N; k++) begin
               if (m_left == 0 && req[(m_last + k) % N]) begin
                  m_id   = (m_last + k) % N;
                  m_left = 2;
               end
            end
            m_last = m_id;
            m_cur  = ref_op(ra[m_id], rb[m_id], rs[m_id]);
         end
         @(negedge clk);
      end
      req = '0;
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
